// File: rtl/monopix2_cmd_tx.sv
// monopix2_cmd_tx
// Serial command transmitter for TJ-Monopix2. Frames are queued through a
// valid/ready handshake and sent MSB-first as a gapless 16-bit stream. Idle
// slots carry NOOP, and a SYNC frame is inserted after every SYNC_INTERVAL
// non-SYNC frames so the chip decoder stays word-locked.
//
// Optional feature: define MONOPIX2_CMD_TX_PULSE_EN to add the EXT_PULSE
// input. A rising edge on EXT_PULSE queues one PULSE frame, which takes
// priority over FIFO data but not over SYNC.

module monopix2_cmd_tx #(
  parameter int FIFO_DEPTH    = 16,
  parameter int SYNC_INTERVAL = 32
) (
  input  logic        CMD_CLK,
  input  logic        RESETB,
  input  logic [15:0] FRAME_DATA,
  input  logic        FRAME_VALID,
  output logic        FRAME_READY,
`ifdef MONOPIX2_CMD_TX_PULSE_EN
  input  logic        EXT_PULSE,
`endif
  output logic        LVDS_CMD,
  output logic        FRAME_START,
  output logic        BUSY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SYNC_INTERVAL + 1);

  localparam logic [15:0]   SYNC_WORD  = 16'h817E;
  localparam logic [15:0]   NOOP_WORD  = 16'h6969;
`ifdef MONOPIX2_CMD_TX_PULSE_EN
  localparam logic [15:0]   PULSE_WORD = 16'h5C5C;
`endif
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SC_MAX     = SW'(SYNC_INTERVAL);

  // Serializer state
  logic [15:0]   shiftQ, shiftD;
  logic [3:0]    bitCntQ, bitCntD;
  logic [SW-1:0] syncCntQ, syncCntD;
  logic          dataOnLineQ, dataOnLineD;

  // Frame FIFO state
  logic [15:0]   fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtrQ, wrPtrD;
  logic [AW-1:0] rdPtrQ, rdPtrD;
  logic [CW-1:0] countQ, countD;

  logic loadEdge;
  logic fifoEmpty;
  logic fifoFull;
  logic push;
  logic pop;
  logic selSync;
  logic selPulse;

`ifdef MONOPIX2_CMD_TX_PULSE_EN
  logic extPulseQ;
  logic pulsePendQ, pulsePendD;
  logic pulseRise;
`endif

  assign loadEdge  = (bitCntQ == 4'd15);
  assign fifoEmpty = (countQ == '0);
  assign fifoFull  = (countQ == FULL_COUNT);

  // READY is forced low during reset so nothing is accepted into a FIFO
  // that is being flushed on the same edge.
  assign FRAME_READY = RESETB && !fifoFull;
  assign push        = FRAME_VALID && FRAME_READY;

  assign selSync = loadEdge && (syncCntQ == SC_MAX);

`ifdef MONOPIX2_CMD_TX_PULSE_EN
  assign selPulse  = loadEdge && !selSync && pulsePendQ;
  assign pulseRise = EXT_PULSE && !extPulseQ;
`else
  assign selPulse  = 1'b0;
`endif

  // Data is popped only when neither SYNC nor PULSE claims the slot.
  assign pop = loadEdge && !selSync && !selPulse && !fifoEmpty;

  assign LVDS_CMD    = shiftQ[15];
  assign FRAME_START = (bitCntQ == 4'd0);
  assign BUSY        = (countQ != '0) || dataOnLineQ;

  // Next-state for the serializer: shift on ordinary edges, pick the next frame on the load edge
  always_comb begin
    shiftD      = shiftQ;
    bitCntD     = bitCntQ;
    syncCntD    = syncCntQ;
    dataOnLineD = dataOnLineQ;
    if (loadEdge) begin
      bitCntD = 4'd0;
      if (selSync) begin
        shiftD      = SYNC_WORD;
        syncCntD    = '0;
        dataOnLineD = 1'b0;
      end else if (selPulse) begin
`ifdef MONOPIX2_CMD_TX_PULSE_EN
        shiftD      = PULSE_WORD;
`endif
        syncCntD    = syncCntQ + 1'b1;
        dataOnLineD = 1'b0;
      end else if (!fifoEmpty) begin
        shiftD      = fifoMem[rdPtrQ];
        syncCntD    = syncCntQ + 1'b1;
        dataOnLineD = 1'b1;
      end else begin
        shiftD      = NOOP_WORD;
        syncCntD    = syncCntQ + 1'b1;
        dataOnLineD = 1'b0;
      end
    end else begin
      shiftD  = {shiftQ[14:0], 1'b0};
      bitCntD = bitCntQ + 4'd1;
    end
  end

  // Next-state for the FIFO pointers and occupancy; a simultaneous push and pop keeps the count
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (push) begin
      wrPtrD = wrPtrQ + 1'b1;
    end
    if (pop) begin
      rdPtrD = rdPtrQ + 1'b1;
    end
    case ({push, pop})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase
  end

`ifdef MONOPIX2_CMD_TX_PULSE_EN
  // A new rising edge wins over the clear so an edge arriving on the load edge is not lost
  always_comb begin
    pulsePendD = (pulsePendQ && !selPulse) || pulseRise;
  end
`endif

  // State registers; reset leaves BC at 15 so the first released edge is a load edge, and SC at max so it loads SYNC
  always_ff @(posedge CMD_CLK) begin
    if (!RESETB) begin
      shiftQ      <= '0;
      bitCntQ     <= 4'd15;
      syncCntQ    <= SC_MAX;
      dataOnLineQ <= 1'b0;
      wrPtrQ      <= '0;
      rdPtrQ      <= '0;
      countQ      <= '0;
`ifdef MONOPIX2_CMD_TX_PULSE_EN
      extPulseQ   <= 1'b0;
      pulsePendQ  <= 1'b0;
`endif
    end else begin
      shiftQ      <= shiftD;
      bitCntQ     <= bitCntD;
      syncCntQ    <= syncCntD;
      dataOnLineQ <= dataOnLineD;
      wrPtrQ      <= wrPtrD;
      rdPtrQ      <= rdPtrD;
      countQ      <= countD;
`ifdef MONOPIX2_CMD_TX_PULSE_EN
      extPulseQ   <= EXT_PULSE;
      pulsePendQ  <= pulsePendD;
`endif
    end
  end

  // FIFO storage; needs no reset because occupancy alone decides what is valid
  always_ff @(posedge CMD_CLK) begin
    if (push) begin
      fifoMem[wrPtrQ] <= FRAME_DATA;
    end
  end

endmodule

// File: tb/tb_monopix2_cmd_tx.sv
// Testbench for monopix2_cmd_tx with SYNC_INTERVAL = 4 and FIFO_DEPTH = 16.
// A line monitor deframes LVDS_CMD using FRAME_START and the checks compare
// the received frame list against hand-written expected sequences.

module tb_monopix2_cmd_tx;

  logic        CMD_CLK = 1'b0;
  logic        RESETB = 1'b0;
  logic [15:0] FRAME_DATA = 16'h0000;
  logic        FRAME_VALID = 1'b0;
  logic        FRAME_READY;
  logic        LVDS_CMD;
  logic        FRAME_START;
  logic        BUSY;
`ifdef MONOPIX2_CMD_TX_PULSE_EN
  logic        EXT_PULSE = 1'b0;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  logic [15:0] rxQ[$];
  logic [15:0] expQ[$];
  int          cycleCnt = 0;
  int          monCnt = 0;
  logic [15:0] monShift = 16'h0000;
  int          lastStart = 0;
  bit          lastStartValid = 1'b0;
  int          periodErr = 0;
  bit          busySeen = 1'b0;

  monopix2_cmd_tx #(
    .FIFO_DEPTH   (16),
    .SYNC_INTERVAL(4)
  ) dut (
    .CMD_CLK    (CMD_CLK),
    .RESETB     (RESETB),
    .FRAME_DATA (FRAME_DATA),
    .FRAME_VALID(FRAME_VALID),
    .FRAME_READY(FRAME_READY),
`ifdef MONOPIX2_CMD_TX_PULSE_EN
    .EXT_PULSE  (EXT_PULSE),
`endif
    .LVDS_CMD   (LVDS_CMD),
    .FRAME_START(FRAME_START),
    .BUSY       (BUSY)
  );

  // Free-running command clock
  always #5 CMD_CLK = ~CMD_CLK;

  // Line monitor: samples 1 time unit after each rising edge and rebuilds frames
  always @(posedge CMD_CLK) begin
    #1;
    cycleCnt++;
    if (!RESETB) begin
      monCnt = 0;
      lastStartValid = 1'b0;
    end else begin
      if (BUSY) busySeen = 1'b1;
      if (FRAME_START) begin
        if (lastStartValid && (cycleCnt - lastStart) != 16) periodErr++;
        lastStart = cycleCnt;
        lastStartValid = 1'b1;
        monShift = {15'b0, LVDS_CMD};
        monCnt = 1;
      end else if (monCnt > 0 && monCnt < 16) begin
        monShift = {monShift[14:0], LVDS_CMD};
        monCnt++;
      end
      if (monCnt == 16) begin
        rxQ.push_back(monShift);
        monCnt = 0;
      end
    end
  end

  // Hard stop in case some wait slips past its own bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one word and returns just after the rising edge that accepts it
  task automatic applyStimulus(input logic [15:0] word);
    int guard = 0;
    @(negedge CMD_CLK);
    FRAME_DATA  = word;
    FRAME_VALID = 1'b1;
    while (!FRAME_READY && guard < 200) begin
      @(negedge CMD_CLK);
      guard++;
    end
    if (!FRAME_READY) checkOutput("accept_timeout", {31'b0, FRAME_READY}, 32'd1);
    @(posedge CMD_CLK);
    #1;
  endtask

  task automatic dropValid();
    @(negedge CMD_CLK);
    FRAME_VALID = 1'b0;
  endtask

  // Holds reset for the given number of cycles and releases it on a falling edge
  task automatic resetDut(input int cycles);
    @(negedge CMD_CLK);
    RESETB = 1'b0;
    FRAME_VALID = 1'b0;
    repeat (cycles) @(negedge CMD_CLK);
    RESETB = 1'b1;
    rxQ.delete();
  endtask

  task automatic waitFrames(input int n);
    int guard = 0;
    while (rxQ.size() < n && guard < 3000) begin
      @(negedge CMD_CLK);
      guard++;
    end
    if (rxQ.size() < n) checkOutput("frame_timeout", rxQ.size(), n);
  endtask

  task automatic compareFrames(input string tag);
    waitFrames(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i),
                  (i < rxQ.size()) ? {16'h0, rxQ[i]} : 32'hFFFF_FFFF,
                  {16'h0, expQ[i]});
    end
  endtask

  initial begin
    logic [15:0] words[20];
    logic [15:0] dataSeen[$];
    int i;
    int guard;
    int firstDrop;
    int notReadyRun;
    int starts;

    $display("[TB] start");

    // ---------------- reset state ----------------
    RESETB = 1'b0;
    repeat (3) @(negedge CMD_CLK);
    checkOutput("rst_lvds",  {31'b0, LVDS_CMD},    32'd0);
    checkOutput("rst_start", {31'b0, FRAME_START}, 32'd0);
    checkOutput("rst_ready", {31'b0, FRAME_READY}, 32'd0);
    checkOutput("rst_busy",  {31'b0, BUSY},        32'd0);
    RESETB = 1'b1;
    rxQ.delete();
    busySeen = 1'b0;
    @(posedge CMD_CLK);
    #1;
    checkOutput("rel_lvds",  {31'b0, LVDS_CMD},    32'd1);
    checkOutput("rel_start", {31'b0, FRAME_START}, 32'd1);

    // ---------------- idle stream ----------------
    expQ = '{16'h817E, 16'h6969, 16'h6969, 16'h6969, 16'h6969, 16'h817E, 16'h6969};
    compareFrames("idle");
    checkOutput("idle_busy", {31'b0, busySeen}, 32'd0);

    // ---------------- two frames during the first SYNC ----------------
    resetDut(2);
    applyStimulus(16'h6666);
    checkOutput("busy_first_accept", {31'b0, BUSY}, 32'd1);
    applyStimulus(16'h1234);
    dropValid();
    waitFrames(3);
    checkOutput("busy_last_bit", {31'b0, BUSY}, 32'd1);
    @(negedge CMD_CLK);
    checkOutput("busy_after_noop_load", {31'b0, BUSY}, 32'd0);
    expQ = '{16'h817E, 16'h6666, 16'h1234, 16'h6969, 16'h6969, 16'h817E};
    compareFrames("two");

    // ---------------- FIFO fill with 20 words ----------------
    resetDut(2);
    for (int k = 0; k < 20; k++) words[k] = 16'hA000 + 16'(k * 17);
    i = 0;
    guard = 0;
    firstDrop = -1;
    notReadyRun = 0;
    while (i < 20 && guard < 2000) begin
      @(negedge CMD_CLK);
      FRAME_DATA  = words[i];
      FRAME_VALID = 1'b1;
      if (FRAME_READY) begin
        i++;
      end else begin
        if (firstDrop < 0) firstDrop = i;
        if (i == 17) notReadyRun++;
      end
      guard++;
    end
    dropValid();
    checkOutput("fill_accept_before_drop", firstDrop, 17);
    checkOutput("fill_ready_gap", notReadyRun, 15);
    guard = 0;
    dataSeen.delete();
    while (dataSeen.size() < 20 && guard < 3000) begin
      @(negedge CMD_CLK);
      dataSeen.delete();
      foreach (rxQ[k]) if (rxQ[k] != 16'h817E && rxQ[k] != 16'h6969) dataSeen.push_back(rxQ[k]);
      guard++;
    end
    checkOutput("fill_count", dataSeen.size(), 20);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("fill_word[%0d]", k),
                  (k < dataSeen.size()) ? {16'h0, dataSeen[k]} : 32'hFFFF_FFFF,
                  {16'h0, words[k]});
    end

    // ---------------- SYNC insertion among 10 data frames ----------------
    resetDut(2);
    for (int k = 0; k < 10; k++) applyStimulus(16'h0100 + 16'(k));
    dropValid();
    expQ = '{16'h817E, 16'h0100, 16'h0101, 16'h0102, 16'h0103,
             16'h817E, 16'h0104, 16'h0105, 16'h0106, 16'h0107,
             16'h817E, 16'h0108, 16'h0109, 16'h6969};
    compareFrames("sync10");

    // ---------------- reset in the middle of a data frame ----------------
    resetDut(2);
    applyStimulus(16'hC001);
    applyStimulus(16'hC002);
    applyStimulus(16'hC003);
    applyStimulus(16'hC004);
    dropValid();
    starts = 0;
    guard = 0;
    while (starts == 0 && guard < 100) begin
      @(negedge CMD_CLK);
      if (FRAME_START) starts++;
      guard++;
    end
    checkOutput("mid_found_data_frame", starts, 1);
    repeat (8) @(negedge CMD_CLK);
    checkOutput("mid_busy_before", {31'b0, BUSY}, 32'd1);
    RESETB = 1'b0;
    @(negedge CMD_CLK);
    checkOutput("mid_lvds",  {31'b0, LVDS_CMD},    32'd0);
    checkOutput("mid_start", {31'b0, FRAME_START}, 32'd0);
    checkOutput("mid_busy",  {31'b0, BUSY},        32'd0);
    RESETB = 1'b1;
    rxQ.delete();
    expQ = '{16'h817E, 16'h6969, 16'h6969, 16'h6969, 16'h6969, 16'h817E};
    compareFrames("mid");

`ifdef MONOPIX2_CMD_TX_PULSE_EN
    // ---------------- collapsed external pulses ----------------
    resetDut(2);
    applyStimulus(16'hD001);
    applyStimulus(16'hD002);
    dropValid();
    for (int k = 0; k < 6; k++) begin
      @(negedge CMD_CLK);
      EXT_PULSE = ~EXT_PULSE;
    end
    expQ = '{16'h817E, 16'h5C5C, 16'hD001, 16'hD002, 16'h6969, 16'h817E, 16'h6969};
    compareFrames("pulse");
`endif

    checkOutput("frame_period_err", periodErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
